motor_pwm_drive: RTL
====================

# motor_pwm_drive

Consumer of the 4-bit steering code produced by the line-sensor direction controller. Decodes each code into per-wheel duty targets and motor polarity, then generates two PWM streams plus H-bridge direction pins. Sits between the direction controller and the motor driver pins. Handles glitch-free duty updates, a dead-time interlock on polarity reversal, and optional soft ramping.

## Interface
- PWM_PERIOD, 1000: PWM period in clk cycles, minimum 2; 50 kHz at 50 MHz.
- DUTY_FULL, 1000: straight-line duty; must be ≤ PWM_PERIOD.
- DUTY_VEER, 700: inner-wheel duty for a veer.
- DUTY_HARD, 400: inner-wheel duty for a hard turn.
- DEADTIME_CYCLES, 50_000: cycles both bridge legs are held off before a polarity flip; minimum 1.
- RAMP_STEP, 50: duty change per PWM period; used only with the ramp feature.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- DIR  in  4  steering code. [3:2] gives the side: 10 right, 01 left, 00 none, 11 stop. [1:0] gives severity: 01 veer, 10 hard, 11 ninety.
- Direction  in  1  travel sense: 1 forwards, 0 backwards.
- l_pwm, r_pwm  out  1 each  left and right wheel PWM.
- l_dir, r_dir  out  1 each  wheel polarity: 1 forward, 0 reverse.
- illegal_code  out  1  one-cycle pulse when a newly registered DIR value is undefined.

## Operation
- DIR and Direction are registered once on input (same clock domain). Decode runs on the registered values.
- Decode gives target (duty, polarity) per wheel. In the base polarity, wheel polarity is forward.
  - 0000 PROCEED: both DUTY_FULL.
  - 1001 veer right: L=DUTY_FULL, R=DUTY_VEER.
  - 1010 hard right: L=DUTY_FULL, R=DUTY_HARD.
  - 1011 ninety right: L=DUTY_FULL, R=DUTY_FULL with R reverse (pivot).
  - 0101, 0110, 0111: mirror images of the right-turn codes.
  - 1111 STOP: both 0.
  - Any other code: both 0, and illegal_code pulses on the cycle the registered code changes to it.
- Direction=0 inverts both target polarities. Duty mapping is unchanged.
- PWM counter runs 0..PWM_PERIOD-1 and wraps. wheel_pwm = (cnt < applied_duty). Duty 0 gives constant low; duty PWM_PERIOD gives constant high.
- applied_duty loads only on the cycle cnt wraps to 0, so there are no runt pulses. A target change mid-period takes effect at the next wrap.
- Each wheel has its own FSM with two states, RUN and BRAKE.
  - RUN: if target polarity ≠ wheel_dir, go to BRAKE.
  - BRAKE: force the wheel's pwm low starting the next cycle, even mid-period. Clear applied_duty to 0. Count DEADTIME_CYCLES.
  - End of BRAKE: set wheel_dir to the target polarity sampled on that cycle (no toggle if the target has reverted), then return to RUN.
- Target changes during BRAKE are ignored until BRAKE ends. BRAKE is never cut short.
- The two wheel FSMs are independent. A ninety turn brakes only the reversing wheel.

## Timing
- Reset values: l_pwm=r_pwm=0, l_dir=r_dir=1, illegal_code=0, applied duties 0, cnt 0, both FSMs RUN, input registers 0000/1.
- Reset deassertion: the first PWM period starts with cnt=0. Applied duty stays 0 until the first wrap after the input register captures DIR, which is 1 cycle.
- Latency from DIR change to new duty on the pins: 2 cycles to the target, then up to PWM_PERIOD cycles to the wrap.
- Polarity flip: pwm low 2 cycles after the DIR change. wheel_dir toggles DEADTIME_CYCLES cycles after BRAKE entry. The new duty starts from the following wrap.
- If a wrap and the end of BRAKE fall on the same cycle, BRAKE wins. The duty loads at the next wrap.
- Reset asserted mid-BRAKE or mid-period: all state returns to reset values immediately, asynchronously.

## Configuration
- MOTOR_SOFT_RAMP_EN defined:
  - At each wrap, applied_duty moves toward its target by at most RAMP_STEP, saturating exactly at the target in both directions.
  - After BRAKE, the ramp starts from 0.
- Undefined: applied_duty jumps directly to the target at the wrap. RAMP_STEP is unused.

## Test plan
- Bench parameters for all scenarios: PWM_PERIOD=10, DUTY_FULL=10, DUTY_VEER=7, DUTY_HARD=4, DEADTIME=20, RAMP_STEP=3.
- Reset, then DIR=0000, Direction=1, ramp off -> both pwm constant high from the first wrap after input capture; l_dir=r_dir=1.
- DIR=1010 mid-period -> r_pwm stays at the old duty until the wrap, then high 4 of every 10 cycles; l_pwm constant high.
- DIR=1011 -> r_pwm low 2 cycles later; r_dir goes to 0 after 20 cycles; r_pwm constant high from the next wrap; l unaffected.
- During that BRAKE, DIR returns to 0000 -> BRAKE runs the full 20 cycles, r_dir stays 1, full duty resumes at the wrap.
- DIR=1000 -> illegal_code one-cycle pulse; both pwm low from the next wrap.
- Ramp on, STOP then PROCEED -> duty sequence 3, 6, 9, 10 over successive periods; rst_n low mid-ramp -> all outputs at reset values immediately.

Source files
------------

// File: rtl/motor_pwm_drive.sv
// Two-wheel PWM motor drive: decodes the 4-bit steering code into per-wheel duty/polarity,
// with glitch-free duty updates and a dead-time interlock. Define MOTOR_SOFT_RAMP_EN for soft duty ramping.
module motor_pwm_drive #(
  parameter int PWM_PERIOD      = 1000,
  parameter int DUTY_FULL       = 1000,
  parameter int DUTY_VEER       = 700,
  parameter int DUTY_HARD       = 400,
  parameter int DEADTIME_CYCLES = 50_000,
  parameter int RAMP_STEP       = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] DIR,
  input  logic       Direction,
  output logic       l_pwm,
  output logic       r_pwm,
  output logic       l_dir,
  output logic       r_dir,
  output logic       illegal_code
);

  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int TW = $clog2(DEADTIME_CYCLES + 1);

  localparam logic [DW-1:0] LastCnt  = DW'(PWM_PERIOD - 1);
  localparam logic [TW-1:0] LastDead = TW'(DEADTIME_CYCLES - 1);
  localparam logic [DW-1:0] Full     = DW'(DUTY_FULL);
  localparam logic [DW-1:0] Veer     = DW'(DUTY_VEER);
  localparam logic [DW-1:0] Hard     = DW'(DUTY_HARD);

`ifdef MOTOR_SOFT_RAMP_EN
  localparam bit SoftRamp = 1'b1;
`else
  localparam bit SoftRamp = 1'b0;
`endif

  typedef enum logic {RUN, BRAKE} wheel_state_e;

  typedef struct packed {
    logic [DW-1:0] duty;
    logic          fwd;
  } wheel_tgt_t;

  // Index 0 is the left wheel, index 1 the right wheel.
  logic [3:0]    dir_q;
  logic          direction_q;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_nxt;
  logic          wrap;
  wheel_tgt_t    tgt      [2];
  wheel_state_e  state    [2];
  logic [DW-1:0] duty     [2];
  logic [TW-1:0] dead_cnt [2];
  logic          wdir     [2];
  logic          pwm      [2];

  function automatic logic code_illegal(input logic [3:0] code);
    case (code)
      4'b0000, 4'b1001, 4'b1010, 4'b1011,
      4'b0101, 4'b0110, 4'b0111, 4'b1111: return 1'b0;
      default:                            return 1'b1;
    endcase
  endfunction

  // Without soft ramping the step is unbounded, so the target is taken directly.
  function automatic logic [DW-1:0] next_duty(input logic [DW-1:0] cur, input logic [DW-1:0] target);
    int c;
    int t;
    c = int'(cur);
    t = int'(target);
    if (SoftRamp && (t > c + RAMP_STEP)) return DW'(c + RAMP_STEP);
    if (SoftRamp && (t + RAMP_STEP < c)) return DW'(c - RAMP_STEP);
    return target;
  endfunction

  assign wrap    = (cnt == LastCnt);
  assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    tgt[0] = '{duty: '0, fwd: 1'b1};
    tgt[1] = '{duty: '0, fwd: 1'b1};
    case (dir_q)
      4'b0000: begin tgt[0].duty = Full; tgt[1].duty = Full; end
      4'b1001: begin tgt[0].duty = Full; tgt[1].duty = Veer; end
      4'b1010: begin tgt[0].duty = Full; tgt[1].duty = Hard; end
      4'b1011: begin tgt[0].duty = Full; tgt[1].duty = Full; tgt[1].fwd = 1'b0; end
      4'b0101: begin tgt[0].duty = Veer; tgt[1].duty = Full; end
      4'b0110: begin tgt[0].duty = Hard; tgt[1].duty = Full; end
      4'b0111: begin tgt[0].duty = Full; tgt[1].duty = Full; tgt[0].fwd = 1'b0; end
      default: ;
    endcase
    if (!direction_q) begin
      tgt[0].fwd = ~tgt[0].fwd;
      tgt[1].fwd = ~tgt[1].fwd;
    end
  end

  // pwm is registered from next-cycle counter/duty, so it always equals (cnt < duty).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q        <= 4'b0000;
      direction_q  <= 1'b1;
      illegal_code <= 1'b0;
      cnt          <= '0;
      for (int w = 0; w < 2; w++) begin
        state[w]    <= RUN;
        duty[w]     <= '0;
        dead_cnt[w] <= '0;
        wdir[w]     <= 1'b1;
        pwm[w]      <= 1'b0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      dir_q        <= DIR;
      direction_q  <= Direction;
      illegal_code <= code_illegal(DIR) && (DIR != dir_q);
      cnt          <= cnt_nxt;
      for (int w = 0; w < 2; w++) begin
        case (state[w])
          RUN: begin
            if (tgt[w].fwd != wdir[w]) begin
              state[w]    <= BRAKE;
              dead_cnt[w] <= '0;
              duty[w]     <= '0;
              pwm[w]      <= 1'b0;
            end else if (wrap) begin
              duty[w] <= next_duty(duty[w], tgt[w].duty);
              pwm[w]  <= (cnt_nxt < next_duty(duty[w], tgt[w].duty));
            end else begin
              pwm[w] <= (cnt_nxt < duty[w]);
            end
          end
          BRAKE: begin
            // Bridge legs stay off for the whole dead time; a wrap here does not load a duty.
            duty[w] <= '0;
            pwm[w]  <= 1'b0;
            if (dead_cnt[w] == LastDead) begin
              state[w] <= RUN;
              wdir[w]  <= tgt[w].fwd;
            end else begin
              dead_cnt[w] <= dead_cnt[w] + 1'b1;
            end
          end
          default: state[w] <= RUN;
        endcase
      end
    end
  end

  assign l_pwm = pwm[0];
  assign r_pwm = pwm[1];
  assign l_dir = wdir[0];
  assign r_dir = wdir[1];

endmodule
